// File: rtl/dec_rcv_buffer_pkg.sv
// Shared parameters and beat types for the decoder receive buffer.
package dec_rcv_buffer_pkg;

  localparam int unsigned DEC_SYM      = 4;
  localparam int unsigned EGF_DIM      = 8;
  localparam int unsigned DEC_CW_BEATS = 64;
  localparam int unsigned DEC_CW_SLOTS = 3;

  // Storage depth in beats and derived counter widths.
  localparam int unsigned DEP    = DEC_CW_SLOTS * DEC_CW_BEATS;
  localparam int unsigned BEAT_BITS = DEC_SYM * EGF_DIM;
  localparam int unsigned PTR_W  = $clog2(DEP);
  localparam int unsigned BEAT_W = $clog2(DEC_CW_BEATS);
  localparam int unsigned OCC_W  = $clog2(DEP + 1);
  localparam int unsigned CNT_W  = $clog2(DEC_CW_SLOTS + 1);

  typedef logic [EGF_DIM-1:0]    dec_sym_t;
  typedef dec_sym_t [DEC_SYM-1:0] dec_beat_t;

endpackage

// File: rtl/dec_rcv_buffer_wrap_ctr.sv
// Wrapping up-counter: counts 0..MAX and returns to 0 on the increment at MAX.
module dec_wrap_ctr #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] r_count;

  assign count  = r_count;
  assign at_max = (r_count == W'(MAX));

  // Advance on enable, wrap at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= at_max ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/dec_rcv_buffer.sv
// Decoder-side received-word buffer. Holds whole codewords until the decoder
// releases them with dec_done, then streams them in order to the corrector.
module dec_rcv_buffer
  import dec_rcv_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BEAT_BITS-1:0] in_data,
  input  logic                 dec_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BEAT_BITS-1:0] out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 dec_err
);

  dec_beat_t          r_mem [DEP];
  logic [OCC_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_cw_cnt;
  logic [CNT_W-1:0]   r_credits;
  logic               r_dec_err;

  logic [PTR_W-1:0]   w_wptr;
  logic [PTR_W-1:0]   w_rptr;
  logic [BEAT_W-1:0]  w_wbeat;
  logic [BEAT_W-1:0]  w_rbeat;
  logic               w_wptr_max;
  logic               w_rptr_max;
  logic               w_wbeat_max;
  logic               w_rbeat_max;

  logic               w_wr;
  logic               w_rd;
  logic               w_cw_wr;
  logic               w_cw_rd;
  logic               w_grant;
  logic               w_spurious;

  // Ready/valid come from registered state only; a same-cycle read never frees a slot early.
  assign in_ready   = (r_occ != OCC_W'(DEP));
  assign out_valid  = (r_credits != '0);
  assign out_data   = r_mem[w_rptr];
  assign out_first  = (w_rbeat == '0);
  assign out_last   = w_rbeat_max;
  assign dec_err    = r_dec_err;

  assign w_wr       = in_valid && in_ready;
  assign w_rd       = out_valid && out_ready;
  assign w_cw_wr    = w_wr && w_wbeat_max;
  assign w_cw_rd    = w_rd && w_rbeat_max;
  // A release is only granted for a codeword that is fully stored and not yet credited.
  assign w_grant    = dec_done && (r_credits < r_cw_cnt);
  assign w_spurious = dec_done && (r_credits == r_cw_cnt);

  dec_wrap_ctr #(
    .MAX (DEP - 1),
    .W   (PTR_W)
  ) u_wptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_wr),
    .count  (w_wptr),
    .at_max (w_wptr_max)
  );

  dec_wrap_ctr #(
    .MAX (DEP - 1),
    .W   (PTR_W)
  ) u_rptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_rd),
    .count  (w_rptr),
    .at_max (w_rptr_max)
  );

  dec_wrap_ctr #(
    .MAX (DEC_CW_BEATS - 1),
    .W   (BEAT_W)
  ) u_wbeat (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_wr),
    .count  (w_wbeat),
    .at_max (w_wbeat_max)
  );

  dec_wrap_ctr #(
    .MAX (DEC_CW_BEATS - 1),
    .W   (BEAT_W)
  ) u_rbeat (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_rd),
    .count  (w_rbeat),
    .at_max (w_rbeat_max)
  );

  // Beat storage; cleared on reset so out_data reads zero before any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEP); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[w_wptr] <= dec_beat_t'(in_data);
    end
  end

  // Occupancy in beats: simultaneous read and write cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      unique case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Complete codewords stored and not yet fully read out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_cnt <= '0;
    end else begin
      unique case ({w_cw_wr, w_cw_rd})
        2'b10:   r_cw_cnt <= r_cw_cnt + CNT_W'(1);
        2'b01:   r_cw_cnt <= r_cw_cnt - CNT_W'(1);
        default: r_cw_cnt <= r_cw_cnt;
      endcase
    end
  end

  // Released codewords awaiting or in readout; a grant and a last-beat read cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= '0;
    end else begin
      unique case ({w_grant, w_cw_rd})
        2'b10:   r_credits <= r_credits + CNT_W'(1);
        2'b01:   r_credits <= r_credits - CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Sticky flag for a dec_done that had no stored codeword to release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_err <= 1'b0;
    end else if (w_spurious) begin
      r_dec_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dec_rcv_buffer.sv
// Scoreboard bench for dec_rcv_buffer: accepted beats are queued as expected
// output; a negedge monitor pops and compares every output handshake.
module tb_dec_rcv_buffer;
  import dec_rcv_buffer_pkg::*;

  localparam int unsigned W = BEAT_BITS;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         dec_done = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;
  logic         dec_err;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           tb_wbeat = 0;
  int unsigned  cyc = 0;
  logic         rdy_auto = 1'b0;
  logic         rdy_man = 1'b0;
  logic         pat = 1'b0;
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_data = '0;

  dec_rcv_buffer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dec_done  (dec_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .dec_err   (dec_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Periodic stall pattern for the automatic ready mode.
  always @(posedge clk) begin
    #1;
    pat = ((cyc % 3) != 0);
  end

  always_comb out_ready = rdy_auto ? pat : rdy_man;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: stability under back-pressure and in-order scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_first", 64'(out_first), 64'(e.f));
          chk("out_last", 64'(out_last), 64'(e.l));
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  function automatic logic [W-1:0] mk(input int c, input int i);
    logic [7:0] cb;
    logic [7:0] ib;
    cb = 8'(c);
    ib = 8'(i);
    return {cb, ib, ~ib, cb ^ ib};
  endfunction

  // Entered and left just after a rising edge; in_valid stays high for streaming.
  task automatic push_beat(input logic [W-1:0] d);
    bit   ok;
    exp_t e;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end else begin
      e.d = d;
      e.f = (tb_wbeat == 0);
      e.l = (tb_wbeat == int'(DEC_CW_BEATS) - 1);
      q.push_back(e);
      tb_wbeat = (tb_wbeat + 1) % int'(DEC_CW_BEATS);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_cw(input int c, input int n);
    for (int i = 0; i < n; i++) push_beat(mk(c, i));
    in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    dec_done = 1'b1;
    @(posedge clk);
    #1;
    dec_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 6000; t++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    chk(name, 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    dec_done = 1'b0;
    rdy_auto = 1'b0;
    rdy_man  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    q.delete();
    tb_wbeat = 0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_dec_err", 64'(dec_err), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_out_data", 64'(out_data), 64'd0);
      chk("idle_dec_err", 64'(dec_err), 64'd0);
      chk("idle_out_first", 64'(out_first), 64'd1);
      chk("idle_out_last", 64'(out_last), 64'd0);
    end
    @(posedge clk);
    #1;

    // One codeword, symbols equal beat index, released after the stream
    rdy_man = 1'b1;
    for (int k = 0; k < int'(DEC_CW_BEATS); k++) push_beat({4{8'(k)}});
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("held_until_done", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    pulse_done();
    wait_drain("single_cw");

    // Spurious dec_done sets a sticky error
    pulse_done();
    @(negedge clk);
    chk("err_set", 64'(dec_err), 64'd1);
    chk("err_no_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 64'(dec_err), 64'd1);
    chk("err_still_no_valid", 64'(out_valid), 64'd0);
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(dec_err), 64'd0);
    @(posedge clk);
    #1;

    // Fill all slots, then free exactly one beat
    rdy_man = 1'b0;
    for (int c = 0; c < int'(DEC_CW_SLOTS); c++) push_cw(c, int'(DEC_CW_BEATS));
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = {W{1'b1}};
    repeat (2) begin
      @(negedge clk);
      chk("full_blocks", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulse_done();
    rdy_man = 1'b1;
    @(posedge clk);
    #1;
    rdy_man = 1'b0;
    @(negedge clk);
    chk("ready_after_read", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Back-pressure mid codeword
    for (int k = 0; k < 8; k++) begin
      rdy_man = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk);
      #1;
    end
    rdy_auto = 1'b1;
    pulse_done();
    pulse_done();
    wait_drain("fill_drain");
    @(negedge clk);
    chk("fill_no_err", 64'(dec_err), 64'd0);
    @(posedge clk);
    #1;

    // Five codewords through a three-slot store: both pointers wrap
    do_reset();
    rdy_auto = 1'b1;
    for (int c = 0; c < 5; c++) begin
      push_cw(10 + c, int'(DEC_CW_BEATS));
      pulse_done();
    end
    wait_drain("wrap_drain");

    // Reset mid codeword discards the partial word
    rdy_auto = 1'b0;
    push_cw(20, 30);
    do_reset();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_first", 64'(out_first), 64'd1);
    @(posedge clk);
    #1;
    push_cw(21, int'(DEC_CW_BEATS));
    pulse_done();
    rdy_auto = 1'b1;
    wait_drain("post_rst_drain");
    @(negedge clk);
    chk("final_no_err", 64'(dec_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
